// File: rtl/comporta_pkg.sv
// Shared defaults, seven-segment digit constants and a clog2 helper for the floodgate datapath.
package comporta_pkg;

    localparam int N_POSICOES_DEF  = 8;
    localparam int INTERVALO_DEF   = 50_000_000;
    localparam int PWM_PERIODO_DEF = 1_000_000;
    localparam int PULSO_MIN_DEF   = 50_000;
    localparam int PULSO_PASSO_DEF = 6_250;

    // Active-low gfedcba patterns for hex digits 0-F.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2_min1(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        if (r == 0) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm.sv
// Servo PWM: free-running period counter, width latched at each period start, registered compare output.
module servo_pwm
    import comporta_pkg::*;
#(
    parameter int POS_W       = 3,
    parameter int PWM_PERIODO = PWM_PERIODO_DEF,
    parameter int PULSO_MIN   = PULSO_MIN_DEF,
    parameter int PULSO_PASSO = PULSO_PASSO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [POS_W-1:0] i_posicao,
    output logic             o_pwm
);

    localparam int CNT_W = clog2_min1(PWM_PERIODO);
    localparam int WID_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIODO - 1);
    localparam logic [WID_W-1:0] WID_MAX  = WID_W'(PWM_PERIODO - 1);
    localparam logic [WID_W-1:0] WID_RST  = (PULSO_MIN > PWM_PERIODO - 1) ? WID_MAX : WID_W'(PULSO_MIN);

    logic [CNT_W-1:0] r_count;
    logic [WID_W-1:0] r_width;
    logic             r_pwm;
    logic [31:0]      w_width_raw;
    logic [WID_W-1:0] w_width;
    logic [WID_W-1:0] w_cmp_width;

    assign w_width_raw = 32'(PULSO_MIN) + 32'(i_posicao) * 32'(PULSO_PASSO);

    // Clamp the requested width and pick the width that governs the current cycle.
    always_comb begin
        if (w_width_raw > 32'(PWM_PERIODO - 1)) begin
            w_width = WID_MAX;
        end else begin
            w_width = w_width_raw[WID_W-1:0];
        end
        // At count 0 the new width is being latched, so compare against it directly.
        if (r_count == {CNT_W{1'b0}}) begin
            w_cmp_width = w_width;
        end else begin
            w_cmp_width = r_width;
        end
    end

    // Period counter, width latch and registered pwm output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
            r_width <= WID_RST;
            r_pwm   <= 1'b0;
        end else begin
            if (r_count == CNT_LAST) begin
                r_count <= {CNT_W{1'b0}};
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_count == {CNT_W{1'b0}}) begin
                r_width <= w_width;
            end else begin
                r_width <= r_width;
            end
            r_pwm <= ({1'b0, r_count} < w_cmp_width);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/comporta_fd.sv
// Floodgate datapath: saturating position counter, interval timer, status flags and servo PWM.
// Optional macro COMPORTA_HEX_EN adds a registered seven-segment position output dbHexPosicao.
module comporta_fd
    import comporta_pkg::*;
#(
    parameter int N_POSICOES  = N_POSICOES_DEF,
    parameter int INTERVALO   = INTERVALO_DEF,
    parameter int PWM_PERIODO = PWM_PERIODO_DEF,
    parameter int PULSO_MIN   = PULSO_MIN_DEF,
    parameter int PULSO_PASSO = PULSO_PASSO_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic abrirComporta,
    input  logic contaUpdown,
    input  logic zeraUpdown,
    input  logic contaIntervalo,
    input  logic zeraIntervalo,
    output logic inicioPosicao,
    output logic fimPosicao,
    output logic fimContadorIntervalo,
    output logic pwm,
    output logic [clog2_min1(N_POSICOES)-1:0] dbPosicao
`ifdef COMPORTA_HEX_EN
    ,
    output logic [6:0] dbHexPosicao
`endif
);

    localparam int POS_W = clog2_min1(N_POSICOES);
    localparam int ITV_W = clog2_min1(INTERVALO);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POSICOES - 1);
    localparam logic [ITV_W-1:0] ITV_MAX = ITV_W'(INTERVALO - 1);

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_next;
    logic [ITV_W-1:0] r_itv;
    logic [ITV_W-1:0] w_itv_next;

    // Next position (clear beats count, saturating at both ends) and next interval count.
    always_comb begin
        w_pos_next = r_pos;
        if (zeraUpdown) begin
            w_pos_next = {POS_W{1'b0}};
        end else if (contaUpdown && abrirComporta) begin
            if (r_pos != POS_MAX) begin
                w_pos_next = r_pos + POS_W'(1);
            end else begin
                w_pos_next = r_pos;
            end
        end else if (contaUpdown) begin
            if (r_pos != {POS_W{1'b0}}) begin
                w_pos_next = r_pos - POS_W'(1);
            end else begin
                w_pos_next = r_pos;
            end
        end else begin
            w_pos_next = r_pos;
        end

        w_itv_next = r_itv;
        if (zeraIntervalo) begin
            w_itv_next = {ITV_W{1'b0}};
        end else if (contaIntervalo) begin
            if (r_itv == ITV_MAX) begin
                w_itv_next = {ITV_W{1'b0}};
            end else begin
                w_itv_next = r_itv + ITV_W'(1);
            end
        end else begin
            w_itv_next = r_itv;
        end
    end

    // Position and interval registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pos <= {POS_W{1'b0}};
            r_itv <= {ITV_W{1'b0}};
        end else begin
            r_pos <= w_pos_next;
            r_itv <= w_itv_next;
        end
    end

    assign inicioPosicao        = (r_pos == {POS_W{1'b0}});
    assign fimPosicao           = (r_pos == POS_MAX);
    assign fimContadorIntervalo = (r_itv == ITV_MAX);
    assign dbPosicao            = r_pos;

    servo_pwm #(
        .POS_W       (POS_W),
        .PWM_PERIODO (PWM_PERIODO),
        .PULSO_MIN   (PULSO_MIN),
        .PULSO_PASSO (PULSO_PASSO)
    ) u_servo_pwm (
        .clock     (clock),
        .reset     (reset),
        .i_posicao (r_pos),
        .o_pwm     (pwm)
    );

`ifdef COMPORTA_HEX_EN
    logic [6:0] r_hex;
    logic [3:0] w_hex_idx;

    assign w_hex_idx = 4'(w_pos_next);

    // Seven-segment encoding tracks the position register in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hex <= 7'b1000000;
        end else begin
            r_hex <= SEG7_LUT[w_hex_idx];
        end
    end

    assign dbHexPosicao = r_hex;
`endif

endmodule

// File: tb/tb_comporta_fd.sv
// Directed, table-driven bench for comporta_fd with small parameters (8 positions, 100-cycle PWM period).
module tb_comporta_fd;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       abrirComporta = 1'b0;
    logic       contaUpdown = 1'b0;
    logic       zeraUpdown = 1'b0;
    logic       contaIntervalo = 1'b0;
    logic       zeraIntervalo = 1'b0;
    logic       inicioPosicao;
    logic       fimPosicao;
    logic       fimContadorIntervalo;
    logic       pwm;
    logic [2:0] dbPosicao;
`ifdef COMPORTA_HEX_EN
    logic [6:0] dbHexPosicao;
    logic [6:0] hex_exp [8];
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       abrir;
        logic       cu;
        logic       zu;
        logic       ci;
        logic       zi;
        logic [2:0] pos;
        logic       ini;
        logic       fim;
        logic       fi;
    } vec_t;

    vec_t vecs[$];

    comporta_fd #(
        .N_POSICOES  (8),
        .INTERVALO   (4),
        .PWM_PERIODO (100),
        .PULSO_MIN   (10),
        .PULSO_PASSO (5)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .abrirComporta        (abrirComporta),
        .contaUpdown          (contaUpdown),
        .zeraUpdown           (zeraUpdown),
        .contaIntervalo       (contaIntervalo),
        .zeraIntervalo        (zeraIntervalo),
        .inicioPosicao        (inicioPosicao),
        .fimPosicao           (fimPosicao),
        .fimContadorIntervalo (fimContadorIntervalo),
        .pwm                  (pwm),
        .dbPosicao            (dbPosicao)
`ifdef COMPORTA_HEX_EN
        ,
        .dbHexPosicao         (dbHexPosicao)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic abrir, input logic cu, input logic zu, input logic ci,
                                input logic zi, input int pos, input logic ini, input logic fim,
                                input logic fi);
        vec_t v;
        v.abrir = abrir; v.cu = cu; v.zu = zu; v.ci = ci; v.zi = zi;
        v.pos = 3'(pos); v.ini = ini; v.fim = fim; v.fi = fi;
        return v;
    endfunction

    int bucket [3];

    initial begin
`ifdef COMPORTA_HEX_EN
        hex_exp = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
`endif
        // Reset state
        #2;
        chk("rst_pos", int'(dbPosicao), 0);
        chk("rst_flags", int'({inicioPosicao, fimPosicao, fimContadorIntervalo}), 3'b100);
        chk("rst_pwm", int'(pwm), 0);
`ifdef COMPORTA_HEX_EN
        chk("rst_hex", int'(dbHexPosicao), 7'b1000000);
`endif
        #3 reset = 1'b0;

        // Idle, latch-timing and mid-period position change over three PWM periods
        bucket = '{0, 0, 0};
        abrirComporta = 1'b1;
        for (int e = 1; e <= 301; e++) begin
            contaUpdown = (e >= 6 && e <= 8) || e == 141 || e == 142;
            tick();
            if (e <= 300 && pwm) bucket[(e - 1) / 100]++;
            if (e == 5) begin
                chk("idle_pos", int'(dbPosicao), 0);
                chk("idle_flags", int'({inicioPosicao, fimPosicao, fimContadorIntervalo}), 3'b100);
            end
            if (e == 100) chk("pos_before_change", int'(dbPosicao), 3);
        end
        contaUpdown = 1'b0;
        chk("pwm_high_period0", bucket[0], 10);
        chk("pwm_high_period1", bucket[1], 25);
        chk("pwm_high_period2", bucket[2], 35);
        chk("pos_after_change", int'(dbPosicao), 5);
        chk("pwm_start_period3", int'(pwm), 1);

        // Asynchronous reset mid-period
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_pos", int'(dbPosicao), 0);
`ifdef COMPORTA_HEX_EN
        chk("async_rst_hex", int'(dbHexPosicao), 7'b1000000);
`endif
        #2 reset = 1'b0;
        bucket[0] = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (pwm) bucket[0]++;
        end
        chk("pwm_high_after_rst", bucket[0], 10);

        // Vector table: open run, close run, interval wrap, priorities, concurrency
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(1, 1, 0, 0, 0, (i < 7) ? i : 7, 0, i >= 7, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 0, 0, (i < 7) ? 7 - i : 0, i >= 7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 1
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 2
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1)); // itv 3
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 1
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 2
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1)); // itv 3
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0)); // itv 1
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0)); // clear wins -> itv 0
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0)); // pos 1, itv 1
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0, 0)); // clear wins -> pos 0, itv 2
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1)); // itv 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1)); // hold at 3
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0)); // itv 0
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0)); // pos 1
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0)); // clear -> pos 0

        foreach (vecs[i]) begin
            abrirComporta  = vecs[i].abrir;
            contaUpdown    = vecs[i].cu;
            zeraUpdown     = vecs[i].zu;
            contaIntervalo = vecs[i].ci;
            zeraIntervalo  = vecs[i].zi;
            tick();
            chk($sformatf("vec%0d_pos_flags", i),
                int'({dbPosicao, inicioPosicao, fimPosicao, fimContadorIntervalo}),
                int'({vecs[i].pos, vecs[i].ini, vecs[i].fim, vecs[i].fi}));
`ifdef COMPORTA_HEX_EN
            chk($sformatf("vec%0d_hex", i), int'(dbHexPosicao), int'(hex_exp[vecs[i].pos]));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
